// File: rtl/mps_aie_mux_cal.sv
// Time-multiplexed active-interlock envelope calculator: per-channel scaled position/angle,
// symmetric limit check, persistence filter, latched interlocks and first-fault capture.
//
// state | meaning
// IDLE  | waiting for a frame strobe
// RUN   | issuing one channel per cycle into the pipeline
// DRAIN | all channels issued, waiting for the last result
module mps_aie_mux_cal #(
  parameter int NCH  = 4,
  parameter int DW   = 32,
  parameter int FRAC = 14,
  parameter int PW   = 8
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic              start,
  input  logic              cal_enable,
  input  logic              enable,
  input  logic              mode,
  input  logic [DW-1:0]     s_i,
  input  logic [PW-1:0]     persist,
  input  logic              il_clear,
  input  logic [NCH*DW-1:0] x1_bus,
  input  logic [NCH*DW-1:0] x2_bus,
  input  logic [NCH*DW-1:0] lim_bus,
  output logic [NCH*DW-1:0] pos_bus,
  output logic [NCH*DW-1:0] err_bus,
  output logic [NCH-1:0]    pre_il,
  output logic [NCH-1:0]    il,
  output logic              il_any,
  output logic [3:0]        first_fault,
  output logic              ff_valid,
  output logic              datavalid,
  output logic              busy,
  output logic              overrun
);

  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int PRW = 2*DW + 1;
  localparam int RW  = PRW + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t r_state;
  logic [CW-1:0] r_cnt;
  logic r_busy, r_overrun;

  logic signed [DW-1:0] r_x1 [NCH];
  logic signed [DW-1:0] r_x2 [NCH];
  logic [DW-1:0]        r_lim [NCH];
  logic signed [DW-1:0] r_s;
  logic r_mode, r_cal, r_en;
  logic [PW-1:0] r_persist;

  logic                 r_s1_v;
  logic [CW-1:0]        r_s1_ch;
  logic signed [DW:0]   r_s1_diff;
  logic signed [DW-1:0] r_s1_x1;

  logic                  r_s2_v;
  logic [CW-1:0]         r_s2_ch;
  logic signed [PRW-1:0] r_s2_prod;
  logic signed [DW-1:0]  r_s2_x1;

  logic signed [DW-1:0] r_pos [NCH];
  logic signed [DW-1:0] r_err [NCH];
  logic [PW-1:0]        r_pcnt [NCH];
  logic [NCH-1:0]       r_pre, r_il;
  logic                 r_il_any, r_dv, r_ff_valid;
  logic [CW-1:0]        r_ff;

  function automatic logic signed [DW-1:0] sat(input logic signed [RW-1:0] v);
    if (v[RW-1:DW-1] == {(RW-DW+1){v[RW-1]}})
      return v[DW-1:0];
    else if (v[RW-1])
      return {1'b1, {(DW-1){1'b0}}};
    else
      return {1'b0, {(DW-1){1'b1}}};
  endfunction

  // Issue stage: select the channel being issued from the frame snapshot
  logic signed [DW-1:0] w_x1_sel, w_x2_sel;
  logic signed [DW:0]   w_diff;
  assign w_x1_sel = r_x1[r_cnt];
  assign w_x2_sel = r_x2[r_cnt];
  assign w_diff   = {w_x2_sel[DW-1], w_x2_sel} - {w_x1_sel[DW-1], w_x1_sel};

  logic signed [PRW-1:0] w_mul;
  assign w_mul = $signed({{(PRW-DW-1){r_s1_diff[DW]}}, r_s1_diff})
               * $signed({{(PRW-DW){r_s[DW-1]}}, r_s});

  logic signed [RW-1:0] w_prod_ext, w_x1_ext, w_sum, w_res_full;
  logic signed [DW-1:0] w_res, w_err;
  logic signed [RW-1:0] w_res_e, w_lim_e, w_err_full;
  logic [DW-1:0]        w_lim;
  logic                 w_hi, w_lo, w_viol;

  assign w_prod_ext = {r_s2_prod[PRW-1], r_s2_prod};
  assign w_x1_ext   = {{(RW-DW){r_s2_x1[DW-1]}}, r_s2_x1};
  assign w_sum      = r_mode ? w_prod_ext : (w_prod_ext + w_x1_ext);
  assign w_res_full = r_cal ? w_sum : w_x1_ext;
  assign w_res      = sat(w_res_full);

  // Limits are unsigned magnitudes, so compare in a widened signed domain
  assign w_lim      = r_lim[r_s2_ch];
  assign w_res_e    = {{(RW-DW){w_res[DW-1]}}, w_res};
  assign w_lim_e    = {{(RW-DW){1'b0}}, w_lim};
  assign w_hi       = (w_res_e > w_lim_e);
  assign w_lo       = (w_res_e < -w_lim_e);
  assign w_viol     = w_hi | w_lo;
  assign w_err_full = w_hi ? (w_res_e - w_lim_e) : (w_lo ? (w_res_e + w_lim_e) : '0);
  assign w_err      = sat(w_err_full);

  logic [PW-1:0]  w_pcnt_cur, w_pcnt_nxt, w_thr;
  logic           w_trip, w_ff_cap;
  logic [NCH-1:0] w_trip_vec, w_il_nxt;

  assign w_pcnt_cur = r_pcnt[r_s2_ch];
  assign w_pcnt_nxt = (r_en && w_viol) ?
                      ((w_pcnt_cur == {PW{1'b1}}) ? w_pcnt_cur : w_pcnt_cur + PW'(1)) : '0;
  assign w_thr      = (r_persist == '0) ? PW'(1) : r_persist;
  assign w_trip     = r_s2_v && r_en && w_viol && (w_pcnt_nxt >= w_thr);
  assign w_trip_vec = w_trip ? (NCH'(1) << r_s2_ch) : '0;
  assign w_il_nxt   = (r_il & ~{NCH{il_clear}}) | w_trip_vec;
  // A trip in the clear cycle re-arms first-fault with that channel
  assign w_ff_cap   = w_trip && (il_clear || (!r_ff_valid && !r_il[r_s2_ch]));

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_overrun <= 1'b0;
      r_s       <= '0;
      r_mode    <= 1'b0;
      r_cal     <= 1'b0;
      r_en      <= 1'b0;
      r_persist <= '0;
      for (int i = 0; i < NCH; i++) begin
        r_x1[i]  <= '0;
        r_x2[i]  <= '0;
        r_lim[i] <= '0;
      end
    end else begin
      if (start && r_state != IDLE)
        r_overrun <= 1'b1;
      else if (il_clear)
        r_overrun <= 1'b0;
      case (r_state)
        IDLE: if (start) begin
          for (int i = 0; i < NCH; i++) begin
            r_x1[i]  <= x1_bus[i*DW +: DW];
            r_x2[i]  <= x2_bus[i*DW +: DW];
            r_lim[i] <= lim_bus[i*DW +: DW];
          end
          r_s       <= s_i;
          r_mode    <= mode;
          r_cal     <= cal_enable;
          r_en      <= enable;
          r_persist <= persist;
          r_cnt     <= '0;
          r_busy    <= 1'b1;
          r_state   <= RUN;
        end
        RUN: begin
          if (r_cnt == CW'(NCH-1))
            r_state <= DRAIN;
          r_cnt <= r_cnt + CW'(1);
        end
        DRAIN: if (r_dv) begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      r_s1_v    <= 1'b0;
      r_s1_ch   <= '0;
      r_s1_diff <= '0;
      r_s1_x1   <= '0;
      r_s2_v    <= 1'b0;
      r_s2_ch   <= '0;
      r_s2_prod <= '0;
      r_s2_x1   <= '0;
    end else begin
      r_s1_v    <= (r_state == RUN);
      r_s1_ch   <= r_cnt;
      r_s1_diff <= w_diff;
      r_s1_x1   <= w_x1_sel;
      r_s2_v    <= r_s1_v;
      r_s2_ch   <= r_s1_ch;
      r_s2_prod <= w_mul >>> FRAC;
      r_s2_x1   <= r_s1_x1;
    end
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < NCH; i++) begin
        r_pos[i]  <= '0;
        r_err[i]  <= '0;
        r_pcnt[i] <= '0;
      end
      r_pre      <= '0;
      r_il       <= '0;
      r_il_any   <= 1'b0;
      r_dv       <= 1'b0;
      r_ff       <= '0;
      r_ff_valid <= 1'b0;
    end else begin
      r_dv <= r_s2_v && (r_s2_ch == CW'(NCH-1));
      if (r_s2_v) begin
        r_pos[r_s2_ch]  <= w_res;
        r_err[r_s2_ch]  <= w_err;
        r_pcnt[r_s2_ch] <= w_pcnt_nxt;
        r_pre[r_s2_ch]  <= r_en && w_viol;
      end
      r_il     <= w_il_nxt;
      r_il_any <= |w_il_nxt;
      if (w_ff_cap) begin
        r_ff       <= r_s2_ch;
        r_ff_valid <= 1'b1;
      end else if (il_clear) begin
        r_ff       <= '0;
        r_ff_valid <= 1'b0;
      end
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_out
    assign pos_bus[g*DW +: DW] = r_pos[g];
    assign err_bus[g*DW +: DW] = r_err[g];
  end

  assign pre_il      = r_pre;
  assign il          = r_il;
  assign il_any      = r_il_any;
  assign first_fault = 4'(r_ff);
  assign ff_valid    = r_ff_valid;
  assign datavalid   = r_dv;
  assign busy        = r_busy;
  assign overrun     = r_overrun;

endmodule

// File: tb/tb_mps_aie_mux_cal.sv
// Directed bench for mps_aie_mux_cal: arithmetic, envelope, persistence, latching,
// first-fault, overrun and reset-abort with hand-computed expectations.
module tb_mps_aie_mux_cal;
  localparam int NCH = 4, DW = 32, FRAC = 14, PW = 8;

  logic clk = 1'b0, RESET = 1'b1, start = 1'b0, cal_enable = 1'b0, enable = 1'b0;
  logic mode = 1'b0, il_clear = 1'b0;
  logic [DW-1:0] s_i = '0;
  logic [PW-1:0] persist = '0;
  logic [NCH*DW-1:0] x1_bus = '0, x2_bus = '0, lim_bus = '0;
  logic [NCH*DW-1:0] pos_bus, err_bus;
  logic [NCH-1:0] pre_il, il;
  logic il_any, ff_valid, datavalid, busy, overrun;
  logic [3:0] first_fault;

  mps_aie_mux_cal #(.NCH(NCH), .DW(DW), .FRAC(FRAC), .PW(PW)) dut (
    .clk(clk), .RESET(RESET), .start(start), .cal_enable(cal_enable), .enable(enable),
    .mode(mode), .s_i(s_i), .persist(persist), .il_clear(il_clear),
    .x1_bus(x1_bus), .x2_bus(x2_bus), .lim_bus(lim_bus),
    .pos_bus(pos_bus), .err_bus(err_bus), .pre_il(pre_il), .il(il), .il_any(il_any),
    .first_fault(first_fault), .ff_valid(ff_valid), .datavalid(datavalid),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_assert = 0, n_fail = 0;
  int lat, bcyc, dvcnt;
  logic [NCH-1:0] il_at_dv;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint posv(input int i);
    logic signed [DW-1:0] v;
    v = pos_bus[i*DW +: DW];
    return longint'(v);
  endfunction

  function automatic longint errv(input int i);
    logic signed [DW-1:0] v;
    v = err_bus[i*DW +: DW];
    return longint'(v);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int i, input longint x1, input longint x2, input longint lim);
    x1_bus[i*DW +: DW]  = x1[DW-1:0];
    x2_bus[i*DW +: DW]  = x2[DW-1:0];
    lim_bus[i*DW +: DW] = lim[DW-1:0];
  endtask

  task automatic clear_chs();
    for (int i = 0; i < NCH; i++) set_ch(i, 0, 0, 500);
  endtask

  // Strobe a frame, measure start-to-datavalid latency and busy length
  task automatic do_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 1;
    bcyc = 0;
    while (!datavalid && lat < 40) begin
      if (busy) bcyc++;
      tick();
      lat++;
    end
    if (busy) bcyc++;
    il_at_dv = il;
    check("frame_latency", lat, 7);
    tick();
  endtask

  task automatic pulse_clear();
    il_clear = 1'b1;
    tick();
    il_clear = 1'b0;
  endtask

  initial begin
    // Reset state
    tick(); tick();
    check("rst_pos", longint'(pos_bus[63:0]), 0);
    check("rst_busy", busy, 0);
    check("rst_dv", datavalid, 0);
    check("rst_il", il, 0);
    check("rst_ffv", ff_valid, 0);
    RESET = 1'b0;
    tick();

    // Angle mode, scale 0.5, floor rounding on negative product
    s_i = 32'd8192; mode = 1'b1; cal_enable = 1'b1; enable = 1'b0; persist = 8'd1;
    clear_chs();
    set_ch(0, 0, 1000, 0);
    set_ch(3, 0, -1001, 500);
    do_frame();
    check("busy_cycles", bcyc, 7);
    check("angle_pos0", posv(0), 500);
    check("angle_pos3_floor", posv(3), -501);
    check("err_with_enable_off", errv(0), 500);
    check("pre_il_enable_off", pre_il, 0);
    check("busy_after_frame", busy, 0);

    // Position mode and bypass
    mode = 1'b0;
    clear_chs();
    set_ch(1, 100, 1100, 500);
    do_frame();
    check("mm_pos1", posv(1), 600);
    cal_enable = 1'b0;
    do_frame();
    check("bypass_pos1", posv(1), 100);

    // Envelope edges with persist=1 (bypass so result = x1)
    enable = 1'b1; mode = 1'b1;
    clear_chs();
    set_ch(0, 500, 0, 500);
    set_ch(1, 501, 0, 500);
    set_ch(2, -502, 0, 500);
    set_ch(3, -500, 0, 500);
    do_frame();
    check("pre_il_edges", pre_il, 4'b0110);
    check("il_edges", il, 4'b0110);
    check("err0_equal", errv(0), 0);
    check("err1_plus", errv(1), 1);
    check("err2_minus", errv(2), -2);
    check("err3_neg_equal", errv(3), 0);
    check("ff_first_ch1", first_fault, 1);
    check("ff_valid_set", ff_valid, 1);
    check("il_any_set", il_any, 1);
    pulse_clear();
    check("il_cleared", il, 0);
    check("ffv_cleared", ff_valid, 0);
    check("il_any_cleared", il_any, 0);

    // ch2 trips, then ch0 in a later frame: first fault stays 2
    clear_chs();
    set_ch(2, 600, 0, 500);
    do_frame();
    clear_chs();
    set_ch(0, 600, 0, 500);
    do_frame();
    check("two_trips_il", il, 4'b0101);
    check("ff_ch2", first_fault, 2);
    check("ff_ch2_valid", ff_valid, 1);
    pulse_clear();
    check("ff_clear", ff_valid, 0);

    // Persistence of 3: clean frame resets the run
    persist = 8'd3;
    clear_chs();
    do_frame();
    set_ch(0, 600, 0, 500);
    do_frame();
    do_frame();
    check("persist_2of3", il[0], 0);
    check("persist_pre", pre_il[0], 1);
    set_ch(0, 0, 0, 500);
    do_frame();
    check("persist_clean", il[0], 0);
    set_ch(0, 600, 0, 500);
    do_frame();
    do_frame();
    check("persist_dv2", il_at_dv[0], 0);
    do_frame();
    check("persist_dv3", il_at_dv[0], 1);

    // il_clear coincident with a re-trip of ch0 (result written at T+3)
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    il_clear = 1'b1;
    tick();
    il_clear = 1'b0;
    check("clear_vs_trip_il", il[0], 1);
    check("clear_vs_trip_ffv", ff_valid, 1);
    check("clear_vs_trip_ff", first_fault, 0);
    dvcnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (datavalid) dvcnt++;
      tick();
    end
    check("clear_frame_dv", dvcnt, 1);
    enable = 1'b0;
    pulse_clear();
    check("final_clear_il", il, 0);

    // Saturation both ways, plus a start while busy
    mode = 1'b0; cal_enable = 1'b1; s_i = 32'h0000_8000;
    clear_chs();
    set_ch(0, -64'sd2147483648, 64'sd2147483647, 500);
    set_ch(1, -1000, -64'sd2147483648, 500);
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    start = 1'b1; tick(); start = 1'b0;
    check("overrun_set", overrun, 1);
    dvcnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (datavalid) dvcnt++;
      tick();
    end
    check("overrun_single_dv", dvcnt, 1);
    check("sat_pos_hi", posv(0), 64'sd2147483647);
    check("sat_pos_lo", posv(1), -64'sd2147483648);
    check("overrun_sticky", overrun, 1);

    // Reset during a frame aborts it
    start = 1'b1; tick(); start = 1'b0;
    tick();
    RESET = 1'b1;
    #1;
    check("midrst_pos", longint'(pos_bus[63:0]), 0);
    check("midrst_overrun", overrun, 0);
    check("midrst_busy", busy, 0);
    tick();
    RESET = 1'b0;
    dvcnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (datavalid) dvcnt++;
      tick();
    end
    check("midrst_no_dv", dvcnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
